// File: rtl/char_num_conv.sv
// char_num_conv: iterative binary<->MIX character conversion, one digit per cycle
module char_num_conv #(
    parameter int IN_W   = 30,
    parameter int DIGITS = 10,
    parameter int BYTE   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [IN_W-1:0]        in_bin,
    input  logic [DIGITS*BYTE-1:0] in_char,
    output logic                   busy,
    output logic                   stop,
    output logic [DIGITS*BYTE-1:0] out_char,
    output logic [IN_W-1:0]        out_bin,
    output logic                   overflow
);
    localparam int CW  = $clog2(DIGITS + 1);
    localparam int CHW = DIGITS * BYTE;
    localparam int EW  = IN_W + 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic            mode_r, last;
    logic [CW-1:0]   cnt;
    logic [IN_W-1:0] x, q;
    logic [3:0]      r;
    logic [CHW-1:0]  sreg;
    logic [BYTE-1:0] top_b, dig, chr;
    logic [EW-1:0]   ext;

    // next state plus the per-digit datapath for both directions
    always_comb begin
        last    = cnt == CW'(DIGITS - 1);
        state_n = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
        busy    = state == RUN;
        q       = x / IN_W'(10);
        r       = 4'(x - q * IN_W'(10));
        chr     = BYTE'(30) + BYTE'(r);
        top_b   = sreg[CHW-1 -: BYTE];
        dig     = top_b % BYTE'(10);
        ext     = EW'(out_bin) * EW'(10) + EW'(dig);
    end

    // state register, operand latching and one conversion step per busy cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            stop     <= 1'b0;
            cnt      <= '0;
            mode_r   <= 1'b0;
            x        <= '0;
            sreg     <= '0;
            out_char <= '0;
            out_bin  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            stop  <= 1'b0;
            if (state == IDLE && start) begin
                mode_r   <= mode;
                x        <= in_bin;
                sreg     <= in_char;
                cnt      <= '0;
                out_char <= '0;
                out_bin  <= '0;
                overflow <= 1'b0;
            end else if (state == RUN) begin
                cnt <= cnt + CW'(1);
                if (mode_r) begin
                    out_char <= (out_char >> BYTE) | (CHW'(chr) << (CHW - BYTE));
                    x        <= q;
                    if (last)
                        overflow <= q != '0;
                end else begin
                    out_bin <= ext[IN_W-1:0];
                    sreg    <= sreg << BYTE;
                    if (ext[EW-1:IN_W] != '0)
                        overflow <= 1'b1;
                end
                if (last)
                    stop <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_char_num_conv.sv
// tb_char_num_conv: directed checks of CHAR/NUM conversion, handshake and reset
module tb_char_num_conv;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start4 = 1'b0, mode = 1'b0;
    logic [29:0] in_bin = '0;
    logic [59:0] in_char = '0;
    logic [23:0] in_char4 = '0;
    logic        busy, stop, overflow, busy4, stop4, overflow4;
    logic [59:0] out_char;
    logic [23:0] out_char4;
    logic [29:0] out_bin, out_bin4;
    int          checks = 0, errors = 0;
    int          lat, bc;
    logic        seen;

    localparam logic [59:0] C_A = {6'd30,6'd30,6'd31,6'd32,6'd39,6'd37,6'd37,6'd36,6'd39,6'd39};
    localparam logic [59:0] C_B = {6'd31,6'd30,6'd37,6'd33,6'd37,6'd34,6'd31,6'd38,6'd32,6'd33};
    localparam logic [59:0] C_Z = {10{6'd30}};
    localparam logic [59:0] N_A = {6'd0,6'd0,6'd31,6'd32,6'd39,6'd37,6'd57,6'd47,6'd30,6'd30};
    localparam logic [59:0] N_9 = {10{6'd39}};

    always #5 clk = ~clk;

    char_num_conv dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .in_bin(in_bin),
        .in_char(in_char), .busy(busy), .stop(stop), .out_char(out_char),
        .out_bin(out_bin), .overflow(overflow)
    );

    char_num_conv #(.IN_W(30), .DIGITS(4), .BYTE(6)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(1'b1), .in_bin(in_bin),
        .in_char(in_char4), .busy(busy4), .stop(stop4), .out_char(out_char4),
        .out_bin(out_bin4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic launch(input logic m, input logic [29:0] b, input logic [59:0] c);
        start = 1'b1;
        mode = m;
        in_bin = b;
        in_char = c;
    endtask

    // follows a run from cycle 1 to its stop cycle; poke>0 re-pulses start with junk in that cycle
    task automatic wait_done(input int poke, output int lat_o, output int bc_o);
        @(negedge clk);
        start = 1'b0;
        lat_o = 1;
        bc_o = busy ? 1 : 0;
        while (!stop && lat_o < 40) begin
            if (lat_o == poke) begin
                start = 1'b1;
                mode = ~mode;
                in_bin = 30'd5;
                in_char = N_9;
            end
            @(negedge clk);
            start = 1'b0;
            lat_o++;
            if (busy) bc_o++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_stop", stop, 0);
        check("rst_char", out_char, 0);
        check("rst_bin", out_bin, 0);
        check("rst_ovf", overflow, 0);

        @(negedge clk); launch(1'b1, 30'd12977699, '0);
        wait_done(0, lat, bc);
        check("charA_lat", lat, 11);
        check("charA_busycnt", bc, 10);
        check("charA_busy_at_stop", busy, 0);
        check("charA_char", out_char, C_A);
        check("charA_ovf", overflow, 0);
        check("charA_bin", out_bin, 0);
        @(negedge clk);
        check("charA_stop_1cyc", stop, 0);
        check("charA_hold", out_char, C_A);

        @(negedge clk); launch(1'b1, 30'd1073741823, '0);
        wait_done(0, lat, bc);
        check("charB_char", out_char, C_B);
        check("charB_ovf", overflow, 0);

        @(negedge clk); launch(1'b1, 30'd0, '0);
        wait_done(0, lat, bc);
        check("charZ_char", out_char, C_Z);

        @(negedge clk); launch(1'b0, '0, N_A);
        wait_done(0, lat, bc);
        check("numA_lat", lat, 11);
        check("numA_bin", out_bin, 12977700);
        check("numA_ovf", overflow, 0);
        check("numA_char", out_char, 0);

        @(negedge clk); launch(1'b0, '0, N_9);
        wait_done(0, lat, bc);
        check("num9_bin", out_bin, 336323583);
        check("num9_ovf", overflow, 1);

        @(negedge clk); launch(1'b1, 30'd12977699, '0);
        wait_done(4, lat, bc);
        check("ign_lat", lat, 11);
        check("ign_char", out_char, C_A);
        check("ign_ovf", overflow, 0);
        check("ign_bin", out_bin, 0);

        launch(1'b0, '0, N_9);
        wait_done(0, lat, bc);
        check("chain_lat", lat, 11);
        check("chain_bin", out_bin, 336323583);
        check("chain_ovf", overflow, 1);
        check("chain_char", out_char, 0);

        @(negedge clk); launch(1'b1, 30'd12977699, '0);
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_stop", stop, 0);
        check("abort_char", out_char, 0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (stop) seen = 1'b1;
        end
        check("abort_nostop", seen, 0);
        launch(1'b1, 30'd1073741823, '0);
        wait_done(0, lat, bc);
        check("after_abort_lat", lat, 11);
        check("after_abort_char", out_char, C_B);

        @(negedge clk);
        start4 = 1'b1;
        in_bin = 30'd12977699;
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        while (!stop4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("d4_lat", lat, 5);
        check("d4_char", out_char4, {6'd37,6'd36,6'd39,6'd39});
        check("d4_ovf", overflow4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
